// File: rtl/ram_sp_param_if.sv
// Request/response bundle between the core and the single-port data RAM.
interface ram_sp_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata, rvalid, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata, rvalid, busy
  );
endinterface

// File: rtl/ram_sp_param.sv
// Parametrised single-port RAM with registered read, selectable read-during-write
// behaviour and a post-reset clear sweep.
//
// state    | meaning
// ST_CLEAR | sweeping CLEAR_VALUE into every word, requests ignored
// ST_IDLE  | accepting one read or write per cycle
module ram_sp_param #(
  parameter int               DATA_W         = 8,
  parameter int               ADDR_W         = 8,
  parameter bit               WRITE_FIRST    = 1'b0,
  parameter bit               CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE   = {DATA_W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  ram_sp_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              ready_q;

  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign accept = bus.req & ready_q;

  // Single write port shared by the sweep and core writes; held off while in reset.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.addr;
    mem_wdata = bus.wdata;
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr;
        mem_wdata = CLEAR_VALUE;
      end else if (accept && bus.we) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RST_STATE;
      clr_addr <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ready_q  <= (RST_STATE == ST_IDLE);
    end else begin
      rvalid_q <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (&clr_addr) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            rvalid_q <= 1'b1;
            // The array read sees the pre-edge word, giving read-first on writes.
            if (bus.we && WRITE_FIRST) rdata_q <= bus.wdata;
            else                       rdata_q <= mem[bus.addr];
          end
        end
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = ~ready_q;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
endmodule

// File: tb/tb_ram_sp_param.sv
// Four RAM variants driven by one shared request stream and checked each cycle
// against an array-based model, plus literal expectations from the test plan.
module tb_ram_sp_param;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [7:0]  addr  = '0;
  logic [15:0] wdata = '0;

  always #5 clk = ~clk;

  ram_sp_param_if #(.DATA_W(8),  .ADDR_W(8)) b0 ();
  ram_sp_param_if #(.DATA_W(8),  .ADDR_W(8)) b1 ();
  ram_sp_param_if #(.DATA_W(8),  .ADDR_W(8)) b2 ();
  ram_sp_param_if #(.DATA_W(16), .ADDR_W(4)) b3 ();

  ram_sp_param u0 (.clk(clk), .rst(rst), .bus(b0));
  ram_sp_param #(.WRITE_FIRST(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  ram_sp_param #(.CLEAR_ON_RESET(1'b0)) u2 (.clk(clk), .rst(rst), .bus(b2));
  ram_sp_param #(.DATA_W(16), .ADDR_W(4), .CLEAR_VALUE(16'hA5A5)) u3 (.clk(clk), .rst(rst), .bus(b3));

  assign b0.req = req;  assign b0.we = we;  assign b0.addr = addr;       assign b0.wdata = wdata[7:0];
  assign b1.req = req;  assign b1.we = we;  assign b1.addr = addr;       assign b1.wdata = wdata[7:0];
  assign b2.req = req;  assign b2.we = we;  assign b2.addr = addr;       assign b2.wdata = wdata[7:0];
  assign b3.req = req;  assign b3.we = we;  assign b3.addr = addr[3:0];  assign b3.wdata = wdata;

  logic [15:0] act_rd  [4];
  logic        act_rdy [4];
  logic        act_bsy [4];
  logic        act_rv  [4];
  assign act_rd[0] = {8'h00, b0.rdata};  assign act_rdy[0] = b0.ready;
  assign act_rd[1] = {8'h00, b1.rdata};  assign act_rdy[1] = b1.ready;
  assign act_rd[2] = {8'h00, b2.rdata};  assign act_rdy[2] = b2.ready;
  assign act_rd[3] = b3.rdata;           assign act_rdy[3] = b3.ready;
  assign act_bsy[0] = b0.busy;  assign act_rv[0] = b0.rvalid;
  assign act_bsy[1] = b1.busy;  assign act_rv[1] = b1.rvalid;
  assign act_bsy[2] = b2.busy;  assign act_rv[2] = b2.rvalid;
  assign act_bsy[3] = b3.busy;  assign act_rv[3] = b3.rvalid;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per variant, a word array, known flags and the number of sweep writes left.
  int          depth [4] = '{256, 256, 256, 16};
  bit          wf    [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  bit          cor   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [15:0] cv    [4] = '{16'h0000, 16'h0000, 16'h0000, 16'hA5A5};
  logic [15:0] dmask [4] = '{16'h00FF, 16'h00FF, 16'h00FF, 16'hFFFF};

  logic [15:0] m_mem   [4][256];
  bit          m_known [4][256];
  int          m_left  [4];
  logic [15:0] m_rd    [4];
  bit          m_rdk   [4];
  bit          m_rv    [4];
  int          ma;
  logic [15:0] md;

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_left[k] = cor[k] ? depth[k] : 0;
        m_rd[k]   = '0;
        m_rdk[k]  = 1'b1;
        m_rv[k]   = 1'b0;
      end else begin
        m_rv[k] = 1'b0;
        if (m_left[k] > 0) begin
          m_mem[k][depth[k] - m_left[k]]   = cv[k];
          m_known[k][depth[k] - m_left[k]] = 1'b1;
          m_left[k]--;
        end else if (req) begin
          ma = int'(addr) & (depth[k] - 1);
          md = wdata & dmask[k];
          m_rv[k] = 1'b1;
          if (we && wf[k]) begin
            m_rd[k]  = md;
            m_rdk[k] = 1'b1;
          end else begin
            m_rd[k]  = m_mem[k][ma];
            m_rdk[k] = m_known[k][ma];
          end
          if (we) begin
            m_mem[k][ma]   = md;
            m_known[k][ma] = 1'b1;
          end
        end
      end
    end
  end

  bit chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("u%0d_ready", k),  32'(act_rdy[k]), 32'(m_left[k] == 0));
        check($sformatf("u%0d_busy", k),   32'(act_bsy[k]), 32'(m_left[k] != 0));
        check($sformatf("u%0d_rvalid", k), 32'(act_rv[k]),  32'(m_rv[k]));
        if (m_rdk[k]) check($sformatf("u%0d_rdata", k), 32'(act_rd[k]), 32'(m_rd[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit w, input logic [7:0] a, input logic [15:0] d);
    req = 1'b1; we = w; addr = a; wdata = d;
    step();
    req = 1'b0;
  endtask

  task automatic rd0(input string name, input logic [7:0] a, input logic [7:0] exp);
    issue(1'b0, a, 16'h0);
    check({name, "_rv"}, 32'(act_rv[0]), 32'd1);
    check(name, 32'(act_rd[0]), 32'(exp));
  endtask

  int n;
  int r3;

  initial begin
    step();
    chk_on = 1'b1;
    step();
    check("rst_ready", 32'(act_rdy[0]), 32'd0);
    check("rst_busy", 32'(act_bsy[0]), 32'd1);
    check("rst_rvalid", 32'(act_rv[0]), 32'd0);
    check("rst_rdata", 32'(act_rd[0]), 32'd0);
    check("rst_ready_noclr", 32'(act_rdy[2]), 32'd1);

    // Sweep with a write held on the bus the whole time.
    req = 1'b1; we = 1'b1; addr = 8'h05; wdata = 16'h00FF;
    rst = 1'b0;
    n = 0; r3 = 0;
    while (!act_rdy[0] && n < 2000) begin
      step();
      n++;
      if (act_rdy[3] && r3 == 0) r3 = n;
    end
    check("sweep_len", 32'(n), 32'd256);
    check("sweep_len16", 32'(r3), 32'd16);
    step();
    req = 1'b0;
    check("held_wr_rv", 32'(act_rv[0]), 32'd1);
    check("held_wr_rd_rf", 32'(act_rd[0]), 32'h00);
    check("held_wr_rd_wf", 32'(act_rd[1]), 32'hFF);
    rd0("held_wr_landed", 8'h05, 8'hFF);
    rd0("clr_00", 8'h00, 8'h00);
    rd0("clr_80", 8'h80, 8'h00);
    rd0("clr_ff", 8'hFF, 8'h00);
    step();
    check("rv_single", 32'(act_rv[0]), 32'd0);

    issue(1'b1, 8'h12, 16'h00AB);
    issue(1'b1, 8'h56, 16'h00BC);
    rd0("rd_34", 8'h34, 8'h00);
    rd0("rd_12", 8'h12, 8'hAB);
    rd0("rd_56", 8'h56, 8'hBC);
    step();
    check("rv_drop", 32'(act_rv[0]), 32'd0);

    issue(1'b1, 8'h20, 16'h0011);
    issue(1'b1, 8'h20, 16'h0022);
    check("rdw_read_first", 32'(act_rd[0]), 32'h11);
    check("rdw_write_first", 32'(act_rd[1]), 32'h22);
    issue(1'b0, 8'h20, 16'h0);
    check("rdw_after_rf", 32'(act_rd[0]), 32'h22);
    check("rdw_after_wf", 32'(act_rd[1]), 32'h22);

    issue(1'b1, 8'h0F, 16'h1234);
    issue(1'b0, 8'h0F, 16'h0);
    check("w16_rd", 32'(act_rd[3]), 32'h1234);
    check("w16_rd_narrow", 32'(act_rd[0]), 32'h34);

    req = 1'b1; we = 1'b0; addr = 8'h12;
    step();
    check("b2b_rv0", 32'(act_rv[0]), 32'd1);
    check("b2b_rd0", 32'(act_rd[0]), 32'hAB);
    addr = 8'h56;
    step();
    req = 1'b0;
    check("b2b_rv1", 32'(act_rv[0]), 32'd1);
    check("b2b_rd1", 32'(act_rd[0]), 32'hBC);

    // Reset right after an accept, then abort a sweep part way through.
    issue(1'b1, 8'h7F, 16'h005A);
    rst = 1'b1;
    #1;
    check("rst_after_acc_rv", 32'(act_rv[0]), 32'd0);
    step();
    rst = 1'b0;
    repeat (100) step();
    rst = 1'b1;
    #1;
    check("midsweep_rv", 32'(act_rv[0]), 32'd0);
    check("midsweep_rd", 32'(act_rd[0]), 32'd0);
    step();
    rst = 1'b0;
    n = 0;
    issue(1'b0, 8'h7F, 16'h0);
    n++;
    check("retain_ready", 32'(act_rdy[2]), 32'd1);
    check("retain_rv", 32'(act_rv[2]), 32'd1);
    check("retain_rd", 32'(act_rd[2]), 32'h5A);
    check("busy_ignores_rv", 32'(act_rv[0]), 32'd0);
    while (n < 16) begin
      step();
      n++;
    end
    check("w16_ready", 32'(act_rdy[3]), 32'd1);
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 8'(i), 16'h0);
      n++;
      check($sformatf("w16_clr_%0d", i), 32'(act_rd[3]), 32'hA5A5);
    end
    while (!act_rdy[0] && n < 2000) begin
      step();
      n++;
    end
    check("resweep_len", 32'(n), 32'd256);

    repeat (500) begin
      req   = ($urandom_range(0, 3) != 0);
      we    = 1'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
      wdata = 16'($urandom);
      step();
    end
    req = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_sp_param.md
# ram_sp_param

Parametrised single-port synchronous RAM: the generalised successor to the fixed 256 x 8 RAM. Adds:
- configurable data and address width;
- a registered read with a valid strobe;
- selectable read-during-write behaviour;
- a hardware clear sequencer that zero-fills (or pattern-fills) the array after every reset.

It is the processor's general data memory. The core issues one request per cycle whenever `ready` is high.

## Interface

Parameters:
- `DATA_W`, default 8: word width in bits.
- `ADDR_W`, default 8: address width. Depth is DEPTH = 2**ADDR_W words.
- `WRITE_FIRST`, default 0: read-during-write mode.
  - 0 = read-first: `rdata` returns the old contents.
  - 1 = write-first: `rdata` returns `wdata`.
- `CLEAR_ON_RESET`, default 1: 1 = run the clear sweep after reset; 0 = skip it.
- `CLEAR_VALUE`, default {DATA_W{1'b0}}: word written to every location during the sweep.

Ports:
- `clk`, in, 1: the single clock. All state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req`, in, 1: access request.
- `we`, in, 1: 1 = write, 0 = read. Sampled only with `req`.
- `addr`, in, ADDR_W: word address.
- `wdata`, in, DATA_W: write data.
- `ready`, out, 1: block accepts a request this cycle.
- `rdata`, out, DATA_W: registered read data.
- `rvalid`, out, 1: one-cycle strobe marking new `rdata`.
- `busy`, out, 1: clear sweep in progress. Always the inverse of `ready`.

## Operation

- States: CLEAR and IDLE. Reset forces CLEAR when CLEAR_ON_RESET=1, and IDLE when CLEAR_ON_RESET=0.
- Reset values, applied asynchronously:
  - `rdata` = 0, `rvalid` = 0;
  - internal clear counter `clr_addr` = 0;
  - `ready` = 0 if CLEAR_ON_RESET=1, else 1; `busy` = ~`ready`.
- CLEAR state:
  - Each rising edge writes CLEAR_VALUE to mem[`clr_addr`], then increments `clr_addr`.
  - The edge that writes address DEPTH-1 moves the block to IDLE.
  - `req` is ignored throughout: no write, no `rvalid`.
- IDLE state:
  - A request is accepted on a rising edge where `req` & `ready` = 1.
  - Accepted read: `rdata` <= mem[`addr`]; `rvalid` = 1 for the following cycle.
  - Accepted write: mem[`addr`] <= `wdata`. `rvalid` also pulses, with `rdata` set by mode:
    - WRITE_FIRST=0: `rdata` = the previous mem[`addr`];
    - WRITE_FIRST=1: `rdata` = `wdata`.
- `rdata` holds its last value until the next accepted request. `rvalid` is 0 in any cycle not following an accept.
- Memory contents are not reset directly. They change only through the clear sweep or writes. With CLEAR_ON_RESET=0, contents survive reset.
- `addr` is full range: every value 0..DEPTH-1 is valid. There is no out-of-range case and no wrap beyond DEPTH-1.
- Reset mid-sweep: the sweep aborts and restarts from address 0 on the next rising edge after `rst` falls.
- Reset in the cycle after an accept: `rvalid` drops to 0 immediately.

## Timing

- Read latency is 1 cycle:
  - request sampled at edge N;
  - `rdata`/`rvalid` valid after edge N, for one cycle;
  - `rvalid` low after edge N+1 unless another request was accepted at N+1.
- Throughput: one access per cycle in IDLE. Back-to-back reads to different addresses yield consecutive `rvalid` cycles.
- Sweep length with CLEAR_ON_RESET=1: exactly DEPTH rising edges after `rst` deasserts. `ready` goes high after edge DEPTH, so the first request can be accepted at edge DEPTH+1.
- With CLEAR_ON_RESET=0: the first request can be accepted at the first edge after `rst` deasserts.
- Write then read of the same address on consecutive edges returns the new data. No forwarding hazard exists.

## Test plan

1. **Clear sweep.** Defaults, pulse `rst`. Count edges until `ready`=1; must be 256. Then read addresses 0x00, 0x80, 0xFF; each gives `rdata`=0x00 with `rvalid` one cycle later.
2. **Basic write/read.**
   - Write 0x12 <= 0xAB, write 0x56 <= 0xBC.
   - Read 0x34: `rdata`=0x00.
   - Read 0x12: 0xAB. Read 0x56: 0xBC.
   - `rvalid` pulses exactly once per accepted request.
3. **Read-during-write modes.**
   - Preload 0x20 = 0x11, then write 0x20 <= 0x22.
   - WRITE_FIRST=0: `rdata`=0x11. WRITE_FIRST=1: `rdata`=0x22.
   - A following read of 0x20 gives 0x22 in both modes.
4. **Requests during sweep.**
   - Hold `req`=1, `we`=1, `addr`=0x05, `wdata`=0xFF throughout the sweep.
   - No `rvalid` while `busy`=1.
   - Once `ready` rises, the first accepted write lands. Sweep ordering must not corrupt it: a later read of 0x05 gives 0xFF.
5. **Reset mid-sweep and retention.**
   - Assert `rst` after 100 sweep edges, then release. `ready` must take a full 256 further edges; `rdata`/`rvalid` are 0 during reset.
   - CLEAR_ON_RESET=0: write 0x7F <= 0x5A, pulse `rst`. `ready`=1 on the first edge after release and a read of 0x7F gives 0x5A.
6. **Width generality.** DATA_W=16, ADDR_W=4, CLEAR_VALUE=0xA5A5.
   - Sweep takes 16 edges and every location reads 0xA5A5.
   - Write 0xF <= 0x1234 then read 0xF: 0x1234.
